// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package wb_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of producer-side and register-file-side signals around the writeback arbiter.
// Wiring only, zero latency; lsu_valid/lsu_ready handshake and stall_req carry the backpressure.
// WB_BYPASS_EN adds the byp_raddr/byp_hit/byp_data forwarding lookup.
interface writeback_arbiter_if #(
    parameter int QDEPTH = 4
);
    import wb_pkg::*;

    logic                        alu_valid;
    logic [4:0]                  alu_rd;
    logic [XLEN-1:0]             alu_data;
    logic                        lsu_valid;
    logic                        lsu_ready;
    logic [4:0]                  lsu_rd;
    logic [XLEN-1:0]             lsu_data;
    logic                        stall_req;
    logic [$clog2(QDEPTH+1)-1:0] q_count;
    logic                        rf_wen;
    logic [4:0]                  rf_waddr;
    logic [XLEN-1:0]             rf_wdata;
`ifdef WB_BYPASS_EN
    logic [4:0]                  byp_raddr;
    logic                        byp_hit;
    logic [XLEN-1:0]             byp_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready, stall_req, q_count, rf_wen, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
        , output byp_raddr, input byp_hit, byp_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output lsu_ready, stall_req, q_count, rf_wen, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
        , input byp_raddr, output byp_hit, byp_data
`endif
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t with wrap-around pointers and an occupancy count.
// Head is combinational from state; push/pop take effect at the next edge.
// Push is ignored when full and pop when empty; WB_BYPASS_EN exposes entries oldest-first.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_dat,
    input  logic                       pop,
    output wb_entry_t                  head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef WB_BYPASS_EN
    , output wb_entry_t                entries [DEPTH]
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign do_push  = push && (count < FULL);
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + PW'(i)];
        end
    end
`endif
endmodule

// File: rtl/writeback_arbiter.sv
// Merges the ALU pipe and buffered LSU results onto the single register-file write port (WB_BYPASS_EN: forwarding lookup).
// One cycle: winner chosen in cycle N drives rf_* in cycle N+1.
// ALU never stalls; LSU backpressured via lsu_ready (FIFO full); stall_req pulses after STARVE_LIMIT lost cycles.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave wb
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);

    logic [CW-1:0]   q_count;
    wb_entry_t       head, lsu_ent;
    logic            q_empty, lsu_ready, push, pop, stall_req;
    logic [SW-1:0]   starve_cnt;
    logic            rf_wen_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
`ifdef WB_BYPASS_EN
    wb_entry_t       q_ent [QDEPTH];
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
`endif

    assign q_empty   = (q_count == '0);
    assign lsu_ready = (q_count < Q_FULL);
    // rd==0 results complete the handshake but are dropped before the queue.
    assign push      = wb.lsu_valid && lsu_ready && (wb.lsu_rd != REG_ZERO);
    assign pop       = !wb.alu_valid && !q_empty;
    assign lsu_ent   = '{rd: wb.lsu_rd, data: wb.lsu_data};
    assign stall_req = (starve_cnt == S_MAX);

    wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (lsu_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (q_count)
`ifdef WB_BYPASS_EN
        , .entries (q_ent)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else if (wb.alu_valid) begin
            rf_wen_q   <= (wb.alu_rd != REG_ZERO);
            rf_waddr_q <= wb.alu_rd;
            rf_wdata_q <= wb.alu_data;
        end else if (!q_empty) begin
            rf_wen_q   <= 1'b1;
            rf_waddr_q <= head.rd;
            rf_wdata_q <= head.data;
        end else begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || q_empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != S_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the youngest match wins; the output register overrides all.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (wb.byp_raddr != REG_ZERO) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if ((CW'(i) < q_count) && (q_ent[i].rd == wb.byp_raddr)) begin
                    byp_hit  = 1'b1;
                    byp_data = q_ent[i].data;
                end
            end
            if (rf_wen_q && (rf_waddr_q == wb.byp_raddr)) begin
                byp_hit  = 1'b1;
                byp_data = rf_wdata_q;
            end
        end
    end

    assign wb.byp_hit  = byp_hit;
    assign wb.byp_data = byp_data;
`endif

    assign wb.lsu_ready = lsu_ready;
    assign wb.stall_req = stall_req;
    assign wb.q_count   = q_count;
    assign wb.rf_wen    = rf_wen_q;
    assign wb.rf_waddr  = rf_waddr_q;
    assign wb.rf_wdata  = rf_wdata_q;

    a_no_alu_during_stall: assert property (
        @(posedge clk) disable iff (rst) !(stall_req && wb.alu_valid)
    );
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected register writes go to a scoreboard queue, a monitor checks rf_*.
// Optional WB_BYPASS_EN section checks the youngest-match forwarding lookup.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    wb_entry_t exp_q[$];

    writeback_arbiter_if #(.QDEPTH(4)) wbi ();

    writeback_arbiter #(.QDEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic lsu_offer(input int rd, input logic [31:0] data, input bit expect_write);
        wbi.lsu_valid = 1'b1;
        wbi.lsu_rd    = 5'(rd);
        wbi.lsu_data  = data;
        if (expect_write) exp_q.push_back('{rd: 5'(rd), data: data});
    endtask

    // Scoreboard monitor: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && wbi.rf_wen === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got rd=%0d data=0x%0h expected no write", wbi.rf_waddr, wbi.rf_wdata);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if (wbi.rf_waddr !== e.rd || wbi.rf_wdata !== e.data) begin
                    fails++;
                    $display("FAIL sb_write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             wbi.rf_waddr, wbi.rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        wbi.alu_valid = 1'b0; wbi.alu_rd = '0; wbi.alu_data = '0;
        wbi.lsu_valid = 1'b0; wbi.lsu_rd = '0; wbi.lsu_data = '0;
`ifdef WB_BYPASS_EN
        wbi.byp_raddr = '0;
`endif
        repeat (2) tick();
        chk("rst_wen",   32'(wbi.rf_wen), 0);
        chk("rst_waddr", 32'(wbi.rf_waddr), 0);
        chk("rst_wdata", wbi.rf_wdata, 0);
        chk("rst_qcnt",  32'(wbi.q_count), 0);
        chk("rst_stall", 32'(wbi.stall_req), 0);
        chk("rst_ready", 32'(wbi.lsu_ready), 1);
        rst = 1'b0;
        tick();

        // Single ALU write appears for exactly one cycle.
        wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd3; wbi.alu_data = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd3, data: 32'hDEADBEEF});
        tick();
        chk("t1_wen",   32'(wbi.rf_wen), 1);
        chk("t1_waddr", 32'(wbi.rf_waddr), 3);
        wbi.alu_valid = 1'b0;
        tick();
        chk("t1_wen_off", 32'(wbi.rf_wen), 0);

        // Fill the queue behind a busy ALU (rd=0 keeps the write port quiet), then drain in order.
        wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd0; wbi.alu_data = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            lsu_offer(i, 32'h100 + 32'(i), 1'b1);
            tick();
        end
        wbi.lsu_valid = 1'b0;
        chk("t2_qfull",  32'(wbi.q_count), 4);
        chk("t2_nready", 32'(wbi.lsu_ready), 0);
        wbi.alu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t2_wen",   32'(wbi.rf_wen), 1);
            chk("t2_waddr", 32'(wbi.rf_waddr), 32'(i));
            if (i == 1) chk("t2_ready_after_pop", 32'(wbi.lsu_ready), 1);
        end
        chk("t2_qempty", 32'(wbi.q_count), 0);

        // Full queue: pop with an offer pushes nothing; next cycle push+pop keeps the count.
        wbi.alu_valid = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            lsu_offer(i, 32'h200 + 32'(i), 1'b1);
            tick();
        end
        wbi.alu_valid = 1'b0;
        lsu_offer(9, 32'h209, 1'b0);
        tick();
        chk("t3_full_pop_qcnt", 32'(wbi.q_count), 3);
        chk("t3_ready_again",   32'(wbi.lsu_ready), 1);
        exp_q.push_back('{rd: 5'd9, data: 32'h209});
        tick();
        chk("t3_pushpop_qcnt", 32'(wbi.q_count), 3);
        wbi.lsu_valid = 1'b0;
        n = 0;
        while (wbi.q_count != 0 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_drain", 32'(wbi.q_count), 0);
        tick();

        // Starvation: one queued entry loses to the ALU until stall_req pulses.
        wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd0;
        lsu_offer(11, 32'hBB, 1'b1);
        tick();
        wbi.lsu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t4_stall", 32'(wbi.stall_req), (k == 8) ? 32'd1 : 32'd0);
        end
        wbi.alu_valid = 1'b0;
        tick();
        chk("t4_head_wen",   32'(wbi.rf_wen), 1);
        chk("t4_head_waddr", 32'(wbi.rf_waddr), 11);
        chk("t4_stall_off",  32'(wbi.stall_req), 0);

        // rd==0 filter on both sources.
        wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd0; wbi.alu_data = 32'h55;
        lsu_offer(0, 32'h66, 1'b0);
        chk("t5_ready", 32'(wbi.lsu_ready), 1);
        tick();
        wbi.alu_valid = 1'b0; wbi.lsu_valid = 1'b0;
        chk("t5_wen",  32'(wbi.rf_wen), 0);
        chk("t5_qcnt", 32'(wbi.q_count), 0);
        tick();
        chk("t5_wen_idle", 32'(wbi.rf_wen), 0);

        // Reset mid-operation discards queued entries.
        wbi.alu_valid = 1'b1;
        for (int i = 12; i <= 14; i++) begin
            lsu_offer(i, 32'h300 + 32'(i), 1'b0);
            tick();
        end
        wbi.lsu_valid = 1'b0;
        chk("t6_qcnt_pre", 32'(wbi.q_count), 3);
        wbi.alu_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_qcnt",  32'(wbi.q_count), 0);
        chk("t6_wen",   32'(wbi.rf_wen), 0);
        chk("t6_stall", 32'(wbi.stall_req), 0);
        chk("t6_ready", 32'(wbi.lsu_ready), 1);
        rst = 1'b0;
        tick();

`ifdef WB_BYPASS_EN
        // Youngest queued match is forwarded; rd 0 never hits.
        wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd0;
        lsu_offer(5, 32'h11, 1'b1);
        tick();
        lsu_offer(5, 32'h22, 1'b1);
        tick();
        wbi.lsu_valid = 1'b0;
        wbi.byp_raddr = 5'd5;
        #1;
        chk("byp_hit",  32'(wbi.byp_hit), 1);
        chk("byp_data", wbi.byp_data, 32'h22);
        wbi.byp_raddr = 5'd0;
        #1;
        chk("byp_zero", 32'(wbi.byp_hit), 0);
        wbi.alu_valid = 1'b0;
        repeat (3) tick();
`endif

        repeat (2) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
